// File: rtl/ahb_lite_regbank_slave.sv
// ----------------------------------------------------------------------------
// ahb_lite_regbank_slave
//
// Parametrised AHB-Lite slave exposing NUM_REGS read/write registers plus one
// read-only hardware status word (index NUM_REGS). Accesses support byte and
// halfword lanes through HSIZE. Bad accesses get a two-cycle ERROR response.
// OKAY data phases can be stretched by WAIT_STATES cycles.
//
// Optional build macro: AHB_REGBANK_DOORBELL_EN
//   Adds an irq output. It is set by a nonzero write to register NUM_REGS-1
//   and cleared by a read of that register.
//
// Ports
//   clk_clk        system clock, rising edge
//   reset_reset_n  synchronous active-low reset
//   hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready
//                  AHB-Lite address/data phase inputs
//   hrdata, hreadyout, hresp
//                  AHB-Lite slave response
//   status_in      read-only word returned for index NUM_REGS
//   regs_flat      register i at bits [i*DATA_WIDTH +: DATA_WIDTH]
//   irq            doorbell interrupt (only with AHB_REGBANK_DOORBELL_EN)
// ----------------------------------------------------------------------------
module ahb_lite_regbank_slave #(
   parameter int                     ADDR_WIDTH  = 32,
   parameter int                     DATA_WIDTH  = 32,
   parameter int                     NUM_REGS    = 16,
   parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = '0,
   parameter int                     WAIT_STATES = 0,
   parameter logic [DATA_WIDTH-1:0]  REG_RESET   = '0
) (
   input  logic                           clk_clk,
   input  logic                           reset_reset_n,
   input  logic                           hsel,
   input  logic [ADDR_WIDTH-1:0]          haddr,
   input  logic [1:0]                     htrans,
   input  logic                           hwrite,
   input  logic [2:0]                     hsize,
   input  logic [2:0]                     hburst,
   input  logic [DATA_WIDTH-1:0]          hwdata,
   input  logic                           hready,
   output logic [DATA_WIDTH-1:0]          hrdata,
   output logic                           hreadyout,
   output logic                           hresp,
   input  logic [DATA_WIDTH-1:0]          status_in,
`ifdef AHB_REGBANK_DOORBELL_EN
   output logic                           irq,
`endif
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);

   localparam int NB    = DATA_WIDTH / 8;
   localparam int LG    = $clog2(NB);
   localparam int IDX_W = $clog2(NUM_REGS + 1);

   localparam logic [NB-1:0]    ONE_NB     = 1;
   localparam logic [LG-1:0]    ONE_LG     = 1;
   localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NUM_REGS);
   localparam logic [3:0]       WS_LOAD    = 4'(WAIT_STATES);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             wr_q, wr_d;
   logic [NB-1:0]    bmask_q, bmask_d;

   logic             hready_c;
   logic             hresp_c;
   logic             accept;

   // hburst and the BUSY/IDLE distinction carry no meaning for this slave
   logic unused_inputs;
   assign unused_inputs = ^{hburst, htrans[0]};

   // ---------------------------------------------------------------------
   // Address decode of the current address phase
   // ---------------------------------------------------------------------
   // The extra top bit of the subtraction is the borrow, i.e. haddr < BASE_ADDR.
   logic [ADDR_WIDTH:0]   addr_diff;
   logic [ADDR_WIDTH-1:0] addr_idx;
   logic                  below_base;
   logic                  idx_oob;
   logic                  size_bad;
   logic                  misalign;
   logic [LG-1:0]         align_mask;
   logic [NB-1:0]         lane_mask;
   logic                  acc_err;

   assign addr_diff  = {1'b0, haddr} - {1'b0, BASE_ADDR};
   assign below_base = addr_diff[ADDR_WIDTH];
   assign addr_idx   = addr_diff[ADDR_WIDTH-1:0] >> LG;
   assign idx_oob    = addr_idx > ADDR_WIDTH'(NUM_REGS);
   assign size_bad   = hsize > 3'(LG);
   // A full-width access wraps the shift to zero, so the mask becomes all ones.
   assign align_mask = (ONE_LG << hsize) - ONE_LG;
   assign misalign   = (haddr[LG-1:0] & align_mask) != '0;
   assign acc_err    = below_base | idx_oob | size_bad | misalign;
   // Same wrap trick: 2^hsize contiguous lanes starting at the byte offset.
   assign lane_mask  = ((ONE_NB << (4'd1 << hsize)) - ONE_NB) << haddr[LG-1:0];

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wr_q    <= 1'b0;
         bmask_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wr_q    <= wr_d;
         bmask_q <= bmask_d;
      end
   end

   // ---------------------------------------------------------------------
   // Next state and response
   // ---------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      wr_d     = wr_q;
      bmask_d  = bmask_q;
      hready_c = 1'b1;
      hresp_c  = 1'b0;
      accept   = 1'b0;

      case (state_q)
         ST_WAIT: begin
            hready_c = 1'b0;
            if (cnt_q <= 4'd1) begin
               state_d = ST_DATA;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_DATA: state_d = ST_IDLE;
         ST_ERR1: begin
            hready_c = 1'b0;
            hresp_c  = 1'b1;
            state_d  = ST_ERR2;
         end
         ST_ERR2: begin
            hresp_c = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Our own stall also gates acceptance, so a fabric that drives
      // hready high while we are mid-phase cannot start a second beat.
      accept = hsel & htrans[1] & hready & hready_c;

      if (accept) begin
         idx_d   = addr_idx[IDX_W-1:0];
         wr_d    = hwrite;
         bmask_d = lane_mask;
         if (acc_err) begin
            state_d = ST_ERR1;
            cnt_d   = '0;
         end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WS_LOAD;
         end else begin
            state_d = ST_DATA;
            cnt_d   = '0;
         end
      end
   end

   assign hreadyout = hready_c;
   assign hresp     = hresp_c;

   // ---------------------------------------------------------------------
   // Register bank and write commit
   // ---------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] wr_bits;
   logic                  commit;

   assign commit = (state_q == ST_DATA) & wr_q & (idx_q < STATUS_IDX);

   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_lane
         assign wr_bits[gi*8 +: 8] = {8{bmask_q[gi]}};
      end

      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         logic [DATA_WIDTH-1:0] reg_q;
         always_ff @(posedge clk_clk) begin
            if (!reset_reset_n) begin
               reg_q <= REG_RESET;
            end else if (commit && (idx_q == IDX_W'(gi))) begin
               reg_q <= (reg_q & ~wr_bits) | (hwdata & wr_bits);
            end
         end
         assign regs_flat[gi*DATA_WIDTH +: DATA_WIDTH] = reg_q;
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Read data: full word of the latched index during WAIT/DATA only
   // ---------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] rd_word;

   always_comb begin
      rd_word = '0;
      if (idx_q == STATUS_IDX) begin
         rd_word = status_in;
      end
      for (int i = 0; i < NUM_REGS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            rd_word = regs_flat[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign hrdata = ((state_q == ST_WAIT) || (state_q == ST_DATA)) ? rd_word : '0;

`ifdef AHB_REGBANK_DOORBELL_EN
   // ---------------------------------------------------------------------
   // Doorbell on the last RW register: set wins over clear
   // ---------------------------------------------------------------------
   localparam logic [IDX_W-1:0] DB_IDX = IDX_W'(NUM_REGS - 1);

   logic irq_q;
   logic db_hit;
   logic db_set;
   logic db_clr;

   assign db_hit = (state_q == ST_DATA) && (idx_q == DB_IDX);
   assign db_set = db_hit & wr_q & ((hwdata & wr_bits) != '0);
   assign db_clr = db_hit & ~wr_q;

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         irq_q <= 1'b0;
      end else if (db_set) begin
         irq_q <= 1'b1;
      end else if (db_clr) begin
         irq_q <= 1'b0;
      end
   end

   assign irq = irq_q;
`endif

endmodule

// File: tb/tb_ahb_lite_regbank_slave.sv
// ----------------------------------------------------------------------------
// tb_ahb_lite_regbank_slave
//
// Drives two instances of the register bank (zero and three wait states)
// from a pipelined AHB-Lite master. Each completed data phase is compared
// with a reference model: a plain word array plus the access rules (error
// conditions, lane selection, latency, doorbell).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ahb_lite_regbank_slave;

   localparam int NR  = 16;
   localparam int WS0 = 0;
   localparam int WS1 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n     [2];
   logic          hsel      [2];
   logic [31:0]   haddr     [2];
   logic [1:0]    htrans    [2];
   logic          hwrite    [2];
   logic [2:0]    hsize     [2];
   logic [2:0]    hburst    [2];
   logic [31:0]   hwdata    [2];
   logic [31:0]   hrdata    [2];
   logic          hreadyout [2];
   logic          hresp     [2];
   logic [31:0]   status_in [2];
   logic [NR*32-1:0] regs_flat [2];
`ifdef AHB_REGBANK_DOORBELL_EN
   logic          irq       [2];
`endif

   ahb_lite_regbank_slave #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NR),
      .BASE_ADDR(32'h0), .WAIT_STATES(WS0), .REG_RESET(32'h0)
   ) u_dut0 (
`ifdef AHB_REGBANK_DOORBELL_EN
      .irq(irq[0]),
`endif
      .clk_clk(clk), .reset_reset_n(rst_n[0]), .hsel(hsel[0]), .haddr(haddr[0]),
      .htrans(htrans[0]), .hwrite(hwrite[0]), .hsize(hsize[0]), .hburst(hburst[0]),
      .hwdata(hwdata[0]), .hready(hreadyout[0]), .hrdata(hrdata[0]),
      .hreadyout(hreadyout[0]), .hresp(hresp[0]), .status_in(status_in[0]),
      .regs_flat(regs_flat[0])
   );

   ahb_lite_regbank_slave #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NR),
      .BASE_ADDR(32'h0), .WAIT_STATES(WS1), .REG_RESET(32'h0)
   ) u_dut1 (
`ifdef AHB_REGBANK_DOORBELL_EN
      .irq(irq[1]),
`endif
      .clk_clk(clk), .reset_reset_n(rst_n[1]), .hsel(hsel[1]), .haddr(haddr[1]),
      .htrans(htrans[1]), .hwrite(hwrite[1]), .hsize(hsize[1]), .hburst(hburst[1]),
      .hwdata(hwdata[1]), .hready(hreadyout[1]), .hrdata(hrdata[1]),
      .hreadyout(hreadyout[1]), .hresp(hresp[1]), .status_in(status_in[1]),
      .regs_flat(regs_flat[1])
   );

   // reference model
   logic [31:0] mreg  [2][NR];
   logic        irq_m [2];
   // transfer currently in its data phase
   bit          p_v   [2];
   bit          p_wr  [2];
   bit          p_err [2];
   logic [31:0] p_addr[2];
   logic [31:0] p_wd  [2];
   logic [2:0]  p_sz  [2];

   int n_chk;
   int n_fail;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int ws_of(input int k);
      return (k == 0) ? WS0 : WS1;
   endfunction

   function automatic bit exp_err(input logic [31:0] a, input logic [2:0] sz);
      int unsigned idx;
      idx = a / 4;
      if (idx > NR) return 1'b1;
      if (sz > 3'd2) return 1'b1;
      if ((a % (32'd1 << sz)) != 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check_regs(input int k);
      for (int i = 0; i < NR; i++)
         check_val($sformatf("reg%0d_inst%0d", i, k), regs_flat[k][i*32 +: 32], mreg[k][i]);
   endtask

   // Final cycle of a data phase: compare, then advance the model.
   task automatic finish_beat(input int k, input int cyc);
      int unsigned idx;
      int          exp_cyc;
      int          off;
      int          nbytes;
      bit          nz;
      logic [31:0] exp_rd;
      idx     = p_addr[k] / 4;
      exp_cyc = p_err[k] ? 2 : ws_of(k) + 1;
      check_val("latency", cyc, exp_cyc);
      if (p_err[k]) begin
         check_val("err_rdata", hrdata[k], 32'h0);
      end else if (!p_wr[k]) begin
         exp_rd = (idx == NR) ? status_in[k] : mreg[k][idx];
         check_val("rdata", hrdata[k], exp_rd);
         if (idx == NR - 1) irq_m[k] = 1'b0;
      end else if (idx < NR) begin
         off    = p_addr[k] % 4;
         nbytes = 1 << p_sz[k];
         nz     = 1'b0;
         for (int b = off; b < off + nbytes; b++) begin
            mreg[k][idx][b*8 +: 8] = p_wd[k][b*8 +: 8];
            if (p_wd[k][b*8 +: 8] != 8'h0) nz = 1'b1;
         end
         if (idx == NR - 1 && nz) irq_m[k] = 1'b1;
      end
      $display("xfer inst=%0d %s addr=0x%02h size=%0d wdata=0x%08h rdata=0x%08h resp=%s cycles=%0d",
               k, p_wr[k] ? "WR" : "RD", p_addr[k], p_sz[k], p_wd[k], hrdata[k],
               p_err[k] ? "ERROR" : "OKAY", cyc);
   endtask

   // One address phase (kind: 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ) overlapped with
   // the data phase of the previous transfer. Called at posedge+1, returns at
   // posedge+1 right after the edge that accepted this address phase.
   task automatic bus_cycle(input int k, input int kind, input logic [31:0] a,
                            input bit w, input logic [2:0] sz, input logic [31:0] wd);
      int  cyc;
      int  exp_cyc;
      bit  done;
      hsel[k]   = (kind >= 1) ? 1'b1 : 1'($urandom_range(0, 1));
      htrans[k] = 2'(kind);
      haddr[k]  = a;
      hwrite[k] = w;
      hsize[k]  = sz;
      hburst[k] = 3'($urandom_range(0, 7));
      hwdata[k] = p_v[k] ? p_wd[k] : $urandom;
      exp_cyc   = p_err[k] ? 2 : ws_of(k) + 1;
      cyc  = 0;
      done = 1'b0;
      while (!done) begin
         @(negedge clk);
         cyc++;
`ifdef AHB_REGBANK_DOORBELL_EN
         check_val("irq", irq[k], irq_m[k]);
`endif
         if (p_v[k]) begin
            check_val("hreadyout", hreadyout[k], (cyc >= exp_cyc));
            check_val("hresp", hresp[k], p_err[k]);
            if (hreadyout[k]) begin
               finish_beat(k, cyc);
               done = 1'b1;
            end else if (cyc >= exp_cyc + 8) begin
               check_val("stall_timeout", cyc, exp_cyc);
               done = 1'b1;
            end
         end else begin
            check_val("idle_ready", hreadyout[k], 1'b1);
            check_val("idle_resp", hresp[k], 1'b0);
            check_val("idle_rdata", hrdata[k], 32'h0);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      p_v[k]    = (kind >= 2) && hsel[k];
      p_wr[k]   = w;
      p_addr[k] = a;
      p_sz[k]   = sz;
      p_wd[k]   = wd;
      p_err[k]  = exp_err(a, sz);
   endtask

   task automatic rand_run(input int k, input int n);
      int          r;
      int          kind;
      logic [2:0]  sz;
      logic [31:0] a;
      for (int t = 0; t < n; t++) begin
         r    = $urandom_range(0, 9);
         kind = (r < 2) ? 0 : (r < 3) ? 1 : (r < 6) ? 2 : 3;
         sz   = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
         a    = $urandom_range(0, 'h47);
         if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
         if ($urandom_range(0, 7) == 0) status_in[k] = $urandom;
         bus_cycle(k, kind, a, 1'($urandom_range(0, 1)), sz, $urandom);
      end
      bus_cycle(k, 0, 32'h0, 1'b0, 3'd0, 32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk  = 0;
      n_fail = 0;
      for (int k = 0; k < 2; k++) begin
         rst_n[k] = 1'b0; hsel[k] = 1'b0; haddr[k] = '0; htrans[k] = '0;
         hwrite[k] = 1'b0; hsize[k] = '0; hburst[k] = '0; hwdata[k] = '0;
         status_in[k] = '0; p_v[k] = 1'b0; p_err[k] = 1'b0; irq_m[k] = 1'b0;
         for (int i = 0; i < NR; i++) mreg[k][i] = 32'h0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check_val("reset_ready", hreadyout[k], 1'b1);
         check_val("reset_resp", hresp[k], 1'b0);
         check_val("reset_rdata", hrdata[k], 32'h0);
`ifdef AHB_REGBANK_DOORBELL_EN
         check_val("reset_irq", irq[k], 1'b0);
`endif
         check_regs(k);
      end
      @(posedge clk);
      #1;

      // word write then back-to-back read
      bus_cycle(0, 2, 32'h4, 1'b1, 3'd2, 32'hDEADBEEF);
      bus_cycle(0, 2, 32'h4, 1'b0, 3'd2, 32'h0);
      bus_cycle(0, 0, 32'h0, 1'b0, 3'd0, 32'h0);
      check_val("deadbeef_reg", regs_flat[0][32 +: 32], 32'hDEADBEEF);

      // byte lane write
      bus_cycle(0, 2, 32'h8, 1'b1, 3'd2, 32'h11223344);
      bus_cycle(0, 2, 32'h9, 1'b1, 3'd0, 32'h0000AB00);
      bus_cycle(0, 2, 32'h8, 1'b0, 3'd2, 32'h0);
      bus_cycle(0, 0, 32'h0, 1'b0, 3'd0, 32'h0);
      check_val("byte_lane_reg", regs_flat[0][64 +: 32], 32'h1122AB44);

      // errors: index above the status word, misaligned halfword, oversize
      bus_cycle(0, 2, 32'h44, 1'b0, 3'd2, 32'h0);
      bus_cycle(0, 2, 32'h1, 1'b1, 3'd1, 32'hFFFFFFFF);
      bus_cycle(0, 3, 32'h0, 1'b1, 3'd3, 32'hFFFFFFFF);
      bus_cycle(0, 0, 32'h0, 1'b0, 3'd0, 32'h0);
      check_regs(0);

      // status word: readable, writes ignored
      status_in[0] = 32'h5A5A0001;
      bus_cycle(0, 2, 32'h40, 1'b0, 3'd2, 32'h0);
      bus_cycle(0, 2, 32'h40, 1'b1, 3'd2, 32'h12345678);
      bus_cycle(0, 2, 32'h40, 1'b0, 3'd2, 32'h0);
      bus_cycle(0, 0, 32'h0, 1'b0, 3'd0, 32'h0);
      check_regs(0);

      // burst with a BUSY beat in the middle
      bus_cycle(0, 2, 32'h10, 1'b1, 3'd2, 32'hCAFE0010);
      bus_cycle(0, 1, 32'h14, 1'b1, 3'd2, 32'h0);
      bus_cycle(0, 3, 32'h14, 1'b1, 3'd2, 32'hCAFE0014);
      bus_cycle(0, 0, 32'h0, 1'b0, 3'd0, 32'h0);
      check_regs(0);

`ifdef AHB_REGBANK_DOORBELL_EN
      bus_cycle(0, 2, 32'h3C, 1'b1, 3'd2, 32'h1);
      bus_cycle(0, 0, 32'h0, 1'b0, 3'd0, 32'h0);
      check_val("doorbell_set", irq[0], 1'b1);
      bus_cycle(0, 2, 32'h3C, 1'b0, 3'd2, 32'h0);
      bus_cycle(0, 0, 32'h0, 1'b0, 3'd0, 32'h0);
      check_val("doorbell_clr", irq[0], 1'b0);
`endif

      rand_run(0, 300);
      check_regs(0);

      // three wait states: read of register 0
      bus_cycle(1, 2, 32'h0, 1'b0, 3'd2, 32'h0);
      bus_cycle(1, 0, 32'h0, 1'b0, 3'd0, 32'h0);
      rand_run(1, 120);
      check_regs(1);

      // reset while a write sits in WAIT: nothing commits
      for (int i = 0; i < NR; i++) mreg[1][i] = 32'h0;
      rst_n[1] = 1'b0;
      @(posedge clk);
      #1;
      rst_n[1] = 1'b1;
      irq_m[1] = 1'b0;
      p_v[1]   = 1'b0;
      bus_cycle(1, 2, 32'h3C, 1'b1, 3'd2, 32'h1);
      hsel[1]   = 1'b0;
      htrans[1] = 2'd0;
      hwdata[1] = 32'h1;
      @(negedge clk);
      check_val("mid_wait_stall", hreadyout[1], 1'b0);
      rst_n[1] = 1'b0;
      @(posedge clk);
      #1;
      rst_n[1] = 1'b1;
      p_v[1]   = 1'b0;
      @(negedge clk);
      check_val("rst_wait_ready", hreadyout[1], 1'b1);
      check_val("rst_wait_resp", hresp[1], 1'b0);
      check_val("rst_wait_reg15", regs_flat[1][15*32 +: 32], 32'h0);
`ifdef AHB_REGBANK_DOORBELL_EN
      check_val("rst_wait_irq", irq[1], 1'b0);
`endif
      @(posedge clk);
      #1;
      repeat (5) bus_cycle(1, 0, 32'h0, 1'b0, 3'd0, 32'h0);
      check_regs(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ahb_lite_regbank_slave.md
Name: ahb_lite_regbank_slave

Overview:
Parametrised AHB-Lite slave register bank, the next-generation replacement for the fixed AHB slave in the PCIe/SDRAM Qsys system. It adds the following to a plain slave:
- configurable width, depth, base address and wait states
- byte/halfword lanes via HSIZE
- ERROR responses for bad accesses
- a read-only hardware status word

It sits on the system AHB fabric. Host software reaches it over PCIe. Register contents are exported flat to user logic.

Parameters:
ADDR_WIDTH, 32, HADDR width
DATA_WIDTH, 32, HWDATA/HRDATA width; 32 or 64 only
NUM_REGS, 16, number of RW registers (index 0..NUM_REGS-1); >=1
BASE_ADDR, 0, byte address of register 0; aligned to DATA_WIDTH/8
WAIT_STATES, 0, extra HREADYOUT-low cycles per OKAY data phase; 0..15
REG_RESET, 0, reset value of every RW register

Ports:
clk_clk  input  1  system clock, all logic rising-edge
reset_reset_n  input  1  synchronous active-low reset
hsel  input  1  slave select
haddr  input  ADDR_WIDTH  byte address
htrans  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
hwrite  input  1  1=write
hsize  input  3  transfer size, log2 bytes
hburst  input  3  burst type; informational only
hwdata  input  DATA_WIDTH  write data, valid in data phase
hready  input  1  fabric HREADY, previous data phase complete
hrdata  output  DATA_WIDTH  read data
hreadyout  output  1  slave ready
hresp  output  1  0=OKAY, 1=ERROR
status_in  input  DATA_WIDTH  read-only word at index NUM_REGS
regs_flat  output  NUM_REGS*DATA_WIDTH  register i at bits [i*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Reset (reset_reset_n=0 at a clock edge):
  - registers = REG_RESET
  - hreadyout=1, hresp=0, hrdata=0
  - state=IDLE, wait counter=0
  - any transfer in progress is dropped and no write commits.
- Accept: hsel & htrans[1] & hready at an edge. Latch index, write, size and address low bits. Next cycle is the data phase.
- Index = (haddr-BASE_ADDR) >> log2(DATA_WIDTH/8).
- Error check at accept. ERROR if any of:
  - haddr < BASE_ADDR
  - index > NUM_REGS
  - hsize > log2(DATA_WIDTH/8)
  - haddr not aligned to 2^hsize
- IDLE/BUSY, or hsel=0, with hready=1: no data phase; hreadyout=1, hresp=0.
- States:
  - IDLE: no active data phase.
  - WAIT: hreadyout=0, hresp=0, counter decrements. Entered on an OKAY accept when WAIT_STATES>0. Moves to DATA when counter reaches 1.
  - DATA: hreadyout=1, hresp=0. Entered directly on an OKAY accept when WAIT_STATES=0. Write commits at the end of this cycle. Goes to IDLE, or back to WAIT/DATA/ERR1 if a new transfer is accepted the same edge.
  - ERR1: hreadyout=0, hresp=1. No state change in the bank. Always goes to ERR2.
  - ERR2: hreadyout=1, hresp=1. A new transfer may be accepted here.
- Latency: every OKAY beat takes exactly WAIT_STATES+1 data-phase cycles. Every ERROR beat takes exactly 2.
- Write:
  - On the final DATA cycle, update byte lanes selected by size and address low bits, using the corresponding hwdata bytes. Other lanes are unchanged.
  - A write to index NUM_REGS (status) is ignored, OKAY.
- Read:
  - hrdata = full word of the latched index (status_in for NUM_REGS) while in WAIT/DATA.
  - hrdata = 0 in IDLE/ERR1/ERR2.
  - Masters extract their own lanes.
- Back-to-back write then read of the same index with WAIT_STATES=0: the read returns the new value, because the commit edge precedes the read data phase.
- Bursts (INCR/WRAPx): each beat is handled as an independent transfer with its own address. SEQ and NONSEQ are treated alike.
- A BUSY beat during a burst accepts nothing and returns OKAY zero-wait.

Optional Feature:
Macro AHB_REGBANK_DOORBELL_EN.
- Enabled:
  - adds output irq (1 bit, reset 0).
  - A committed write to index NUM_REGS-1 with any byte lane nonzero sets irq on the commit edge.
  - A completed read of index NUM_REGS-1 clears irq on the last DATA edge.
  - Set wins if set and clear coincide.
  - Register NUM_REGS-1 is still written normally.
- Disabled: no irq port, no doorbell logic.

Test Plan:
- Defaults; reset; write 0xDEADBEEF to 0x4 (word) then read 0x4 -> hreadyout stays 1, write commits, read hrdata=0xDEADBEEF, hresp=0 throughout.
- Byte write 0xAB to 0x9 over 0x11223344 at index 2 -> read index 2 = 0x1122AB44.
- WAIT_STATES=3; read index 0 -> hreadyout low 3 cycles then high 1, hrdata=REG_RESET=0, total 4 data cycles.
- Read 0x44 (index 17 > NUM_REGS=16) -> cycle1 hready 0/hresp 1, cycle2 hready 1/hresp 1, regs unchanged; halfword write to 0x1 -> same ERROR pattern.
- Read 0x40 with status_in=0x5A5A0001 -> 0x5A5A0001; write 0x40 -> OKAY, status read unchanged.
- Doorbell enabled: write 0x1 to index 15 -> irq=1 next cycle; read index 15 -> irq=0 after data phase; reset mid-WAIT (WAIT_STATES=3) with pending write -> reg unchanged, hreadyout=1, irq=0.
